// File: rtl/tdc_pkg.sv
// Shared types and sizing helpers for the TDC sample encoder.
package tdc_pkg;

    localparam int N_DELAY_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE,
        CAP,
        ENC,
        OUT
    } state_e;

    // Width needed to hold every code from 0 to n inclusive.
    function automatic int tdc_code_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tdc_therm2bin.sv
// Combinational first-zero encoder for a thermometer word, with overflow
// (no zero present) and bubble (a 1 above the first zero) flags.
module tdc_therm2bin
    import tdc_pkg::*;
#(
    parameter  int N_DELAY = N_DELAY_DEFAULT,
    localparam int CODE_W  = tdc_code_w(N_DELAY)
) (
    input  logic [N_DELAY-1:0] therm_i,
    output logic [CODE_W-1:0]  code_o,
    output logic               overflow_o,
    output logic               bubble_o
);

    logic found;

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        code_o   = CODE_W'(N_DELAY);
        found    = 1'b0;
        bubble_o = 1'b0;
        for (int i = 0; i < N_DELAY; i++) begin
            // Bubble test uses 'found' from lower bits only, so it sees bits strictly above the code.
            if (found && therm_i[i]) begin
                bubble_o = 1'b1;
            end
            if (!found && !therm_i[i]) begin
                code_o = CODE_W'(i);
                found  = 1'b1;
            end
        end
        overflow_o = !found;
    end

endmodule

// File: rtl/tdc_sample_encoder.sv
// Captures a TDC thermometer word on a sample strobe and emits its first-zero code
// through a valid/ready handshake. Define TDC_BUBBLE_FIX_EN to enable majority bubble correction.
module tdc_sample_encoder
    import tdc_pkg::*;
#(
    parameter  int N_DELAY = N_DELAY_DEFAULT,
    localparam int CODE_W  = tdc_code_w(N_DELAY)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_DELAY-1:0] therm_in,
    input  logic               sample,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CODE_W-1:0]  out_code,
    output logic               out_overflow,
    output logic               out_bubble,
    output logic [7:0]         drop_cnt
);

    state_e               state_q, state_d;
    logic [N_DELAY-1:0]   cap_q, fix_q, fix_d;
    logic [CODE_W-1:0]    code_q, enc_code;
    logic                 ovf_q, bub_q, enc_ovf, enc_bub;
    logic [7:0]           drop_q;
    logic                 capture, drop;

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sample) begin
                    capture = 1'b1;
                    state_d = CAP;
                end
            end
            CAP: begin
                drop    = sample;
                state_d = ENC;
            end
            ENC: begin
                drop    = sample;
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    capture = sample;
                    state_d = sample ? CAP : IDLE;
                end else begin
                    drop = sample;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef TDC_BUBBLE_FIX_EN
    // Pad with the implied 1 below tap 0 and 0 above the last tap.
    logic [N_DELAY+1:0] ext;
    assign ext = {1'b0, cap_q, 1'b1};

    always_comb begin
        fix_d = '0;
        for (int i = 0; i < N_DELAY; i++) begin
            fix_d[i] = (ext[i] & ext[i+1]) | (ext[i+1] & ext[i+2]) | (ext[i] & ext[i+2]);
        end
    end
`else
    assign fix_d = cap_q;
`endif

    tdc_therm2bin #(
        .N_DELAY (N_DELAY)
    ) u_therm2bin (
        .therm_i    (fix_q),
        .code_o     (enc_code),
        .overflow_o (enc_ovf),
        .bubble_o   (enc_bub)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q  <= '0;
            fix_q  <= '0;
            code_q <= '0;
            ovf_q  <= 1'b0;
            bub_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            if (capture) begin
                cap_q <= therm_in;
            end
            if (state_q == CAP) begin
                fix_q <= fix_d;
            end
            if (state_q == ENC) begin
                code_q <= enc_code;
                ovf_q  <= enc_ovf;
                bub_q  <= enc_bub;
            end
            if (drop && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign out_valid    = (state_q == OUT);
    assign out_code     = code_q;
    assign out_overflow = ovf_q;
    assign out_bubble   = bub_q;
    assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_tdc_sample_encoder.sv
// Scoreboard bench for tdc_sample_encoder; expected codes come from a behavioural model.
module tb_tdc_sample_encoder;
    import tdc_pkg::*;

    localparam int N  = N_DELAY_DEFAULT;
    localparam int CW = tdc_code_w(N);

    typedef struct packed {
        logic [CW-1:0] code;
        logic          ovf;
        logic          bub;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  therm_in;
    logic          sample;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_code;
    logic          out_overflow;
    logic          out_bubble;
    logic [7:0]    drop_cnt;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   exp_drop  = 0;

    always #5 clk = ~clk;

    tdc_sample_encoder #(.N_DELAY(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .therm_in     (therm_in),
        .sample       (sample),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_code     (out_code),
        .out_overflow (out_overflow),
        .out_bubble   (out_bubble),
        .drop_cnt     (drop_cnt)
    );

    function automatic exp_t model(input logic [N-1:0] w);
        logic [N-1:0] f;
        exp_t         e;
        int           idx;
        int           ones;
        f    = w;
        ones = 0;
`ifdef TDC_BUBBLE_FIX_EN
        for (int i = 0; i < N; i++) begin
            ones = int'(w[i]);
            ones += (i == 0) ? 1 : int'(w[i-1]);
            ones += (i == N - 1) ? 0 : int'(w[i+1]);
            f[i] = (ones >= 2);
        end
`endif
        idx = 0;
        while (idx < N && f[idx]) idx++;
        e.code = CW'(idx);
        e.ovf  = (idx == N);
        e.bub  = 1'b0;
        for (int j = idx + 1; j < N; j++) begin
            if (f[j]) e.bub = 1'b1;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [N-1:0] w);
        therm_in = w;
        sample   = 1'b1;
        sb.push_back(model(w));
        tick();
        sample   = 1'b0;
    endtask

    // start_lat: clock edges already elapsed since the accepting edge's cycle.
    task automatic await_result(input string tag, input int start_lat, output exp_t e);
        int lat;
        lat = start_lat;
        e   = '0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 3);
        check({tag, "_sb_depth"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_code"}, 32'(out_code), 32'(e.code));
            check({tag, "_ovf"}, 32'(out_overflow), 32'(e.ovf));
            check({tag, "_bubble"}, 32'(out_bubble), 32'(e.bub));
        end
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        tick();
        check({tag, "_valid_drop"}, 32'(out_valid), 0);
    endtask

    initial begin
        logic [N-1:0] vec [7];
        logic [N-1:0] w;
        exp_t         e, held;
        int           k;

        rst_n     = 1'b0;
        sample    = 1'b0;
        out_ready = 1'b1;
        therm_in  = '0;
        #12;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_code", 32'(out_code), 0);
        check("rst_flags", {30'd0, out_overflow, out_bubble}, 0);
        check("rst_drop", 32'(drop_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        vec = '{32'h000000FF, 32'hFFFFFFFF, 32'h00000000, 32'h000004FF,
                32'h00000001, 32'h7FFFFFFF, 32'h0000F0FF};
        foreach (vec[i]) begin
            launch(vec[i]);
            await_result($sformatf("vec%0d", i), 1, e);
            consume($sformatf("vec%0d", i));
        end

        for (int r = 0; r < 8; r++) begin
            k = $urandom_range(0, N);
            w = (k == N) ? '1 : ((N'(1) << k) - N'(1));
            if ($urandom_range(0, 1) == 1) w[$urandom_range(0, N - 1)] ^= 1'b1;
            launch(w);
            await_result($sformatf("rnd%0d", r), 1, e);
            consume($sformatf("rnd%0d", r));
        end

        // Strobes while in CAP and ENC are rejected but the capture completes.
        launch(32'h00003FFF);
        sample = 1'b1;
        tick();
        tick();
        sample = 1'b0;
        exp_drop += 2;
        await_result("capenc", 3, e);
        check("capenc_drop", 32'(drop_cnt), 32'(exp_drop));
        consume("capenc");

        // Stalled output with two rejected strobes, then back-to-back capture.
        out_ready = 1'b0;
        launch(32'h0000FFFF);
        await_result("stall", 1, held);
        for (int c = 0; c < 6; c++) begin
            sample = (c == 1 || c == 3);
            tick();
            check($sformatf("stall_valid%0d", c), 32'(out_valid), 1);
            check($sformatf("stall_code%0d", c), 32'(out_code), 32'(held.code));
        end
        sample = 1'b0;
        exp_drop += 2;
        check("stall_drop", 32'(drop_cnt), 32'(exp_drop));
        out_ready = 1'b1;
        launch(32'h0000000F);
        check("b2b_valid_low", 32'(out_valid), 0);
        await_result("b2b", 1, e);
        consume("b2b");

        // Reset while in ENC discards the pending sample.
        launch(32'h00FFFFFF);
        tick();
        rst_n = 1'b0;
        #2;
        check("midrst_valid", 32'(out_valid), 0);
        check("midrst_drop", 32'(drop_cnt), 0);
        check("midrst_code", 32'(out_code), 0);
        void'(sb.pop_back());
        exp_drop = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("postrst_valid%0d", c), 32'(out_valid), 0);
        end
        check("postrst_drop", 32'(drop_cnt), 32'(exp_drop));
        launch(32'h000007FF);
        await_result("postrst", 1, e);
        consume("postrst");

        // Saturation of the drop counter.
        out_ready = 1'b0;
        launch(32'h0003FFFF);
        await_result("sat", 1, held);
        for (int p = 0; p < 300; p++) begin
            sample = 1'b1;
            tick();
            sample = 1'b0;
            tick();
            if (p == 253) check("sat_drop_254", 32'(drop_cnt), 254);
            if (p == 254) check("sat_drop_255", 32'(drop_cnt), 255);
        end
        check("sat_drop_300", 32'(drop_cnt), 255);
        check("sat_code_held", 32'(out_code), 32'(held.code));
        consume("sat");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
